// File: rtl/gradient_calc.sv
// gradient_calc: streaming Ix/Iy/It gradients over raster frames; define GRAD_COORD_EN to add grad_col/grad_row.
module gradient_calc #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMAGE_WIDTH = 320,
  parameter int IMAGE_HEIGHT = 240
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIXEL_WIDTH-1:0]        pixel_curr,
  input  logic [PIXEL_WIDTH-1:0]        pixel_prev,
  input  logic                          pixel_valid,
  input  logic                          frame_done,
  output logic signed [PIXEL_WIDTH:0]   grad_ix,
  output logic signed [PIXEL_WIDTH:0]   grad_iy,
  output logic signed [PIXEL_WIDTH:0]   grad_it,
  output logic                          grad_valid,
`ifdef GRAD_COORD_EN
  output logic [$clog2(IMAGE_WIDTH)-1:0]  grad_col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] grad_row,
`endif
  output logic                          grad_done,
  output logic                          frame_err
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT + 1);
  localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int GW = PIXEL_WIDTH + 1;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic acc, eol, emit, err_q, err_d, valid_q, fd_q, done_q;
  logic [PIXEL_WIDTH-1:0] cur1_q [IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0] cur2_q [IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0] prv_q [IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0] up_1, up_2, up_p;
  logic [PIXEL_WIDTH-1:0] w0_q, w1a_q, w1b_q, w2_q, pd_q;
  logic signed [GW-1:0] ix_q, iy_q, it_q, ix_d, iy_d, it_d;
  assign acc = pixel_valid && cnt_q != CW'(TOTAL);
  assign eol = x_q == XW'(IMAGE_WIDTH - 1);
  assign emit = acc && x_q >= XW'(2) && y_q >= YW'(2);
  assign up_1 = cur1_q[x_q];
  assign up_2 = cur2_q[x_q];
  assign up_p = prv_q[x_q];
  always_comb begin
    cnt_n = acc ? cnt_q + CW'(1) : cnt_q;
    cnt_d = frame_done ? '0 : cnt_n;
    x_d = frame_done ? '0 : acc ? (eol ? '0 : x_q + XW'(1)) : x_q;
    y_d = frame_done ? '0 : (acc && eol) ? y_q + YW'(1) : y_q;
    err_d = err_q | (pixel_valid && !acc) | (frame_done && cnt_n != CW'(TOTAL));
    ix_d = GW'(up_1) - GW'(w1b_q);
    iy_d = GW'(w0_q) - GW'(w2_q);
    it_d = GW'(w1a_q) - GW'(pd_q);
  end
  // w0/w1a/w2/pd hold column x-1 of rows y, y-1, y-2 and prev-frame y-1; w1b holds column x-2 of row y-1
  always_ff @(posedge clk)
    if (acc) begin
      cur1_q[x_q] <= pixel_curr;
      cur2_q[x_q] <= up_1;
      prv_q[x_q] <= pixel_prev;
      w0_q <= pixel_curr;
      w1a_q <= up_1;
      w1b_q <= w1a_q;
      w2_q <= up_2;
      pd_q <= up_p;
    end
`ifdef GRAD_COORD_EN
  logic [$clog2(IMAGE_WIDTH)-1:0] col_q;
  logic [$clog2(IMAGE_HEIGHT)-1:0] row_q;
  always_ff @(posedge clk)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (emit) begin
      col_q <= x_q - XW'(1);
      row_q <= $clog2(IMAGE_HEIGHT)'(y_q - YW'(1));
    end
  assign grad_col = col_q;
  assign grad_row = row_q;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      fd_q <= 1'b0;
      done_q <= 1'b0;
      ix_q <= '0;
      iy_q <= '0;
      it_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      valid_q <= emit;
      fd_q <= frame_done;
      done_q <= fd_q;
      if (emit) begin
        ix_q <= ix_d;
        iy_q <= iy_d;
        it_q <= it_d;
      end
    end
  assign grad_ix = ix_q;
  assign grad_iy = iy_q;
  assign grad_it = it_q;
  assign grad_valid = valid_q;
  assign grad_done = done_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_gradient_calc.sv
// tb_gradient_calc: scoreboard bench for gradient_calc on an 8x4 and a default 320x240 instance.
module tb_gradient_calc;
  localparam int SW = 8, SH = 4, BW = 320, BH = 240;
  typedef struct packed {
    logic signed [8:0] ix;
    logic signed [8:0] iy;
    logic signed [8:0] it;
  } grad_t;
  typedef struct {
    int pat;
    int d;
    int gap;
    int n_out;
    bit fd_last;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rst_smp = 1'b0;
  logic [7:0] pc = '0, pp = '0;
  logic pv [2] = '{1'b0, 1'b0};
  logic fd [2] = '{1'b0, 1'b0};
  logic signed [8:0] gix [2], giy [2], git [2];
  logic gv [2], gd [2], fe [2];
  grad_t qs [$], qb [$];
  grad_t hold [2];
  int tests = 0, fails = 0, cyc = 0;
  int nout [2], last_out [2], done_cyc [2], ndone [2];
  int cf [BH][BW], pf [BH][BW];
  vec_t vt [5];

  gradient_calc #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH)) dut_s (
    .clk(clk), .rst(rst), .pixel_curr(pc), .pixel_prev(pp), .pixel_valid(pv[0]),
    .frame_done(fd[0]), .grad_ix(gix[0]), .grad_iy(giy[0]), .grad_it(git[0]),
    .grad_valid(gv[0]), .grad_done(gd[0]), .frame_err(fe[0]));
  gradient_calc dut_b (
    .clk(clk), .rst(rst), .pixel_curr(pc), .pixel_prev(pp), .pixel_valid(pv[1]),
    .frame_done(fd[1]), .grad_ix(gix[1]), .grad_iy(giy[1]), .grad_it(git[1]),
    .grad_valid(gv[1]), .grad_done(gd[1]), .frame_err(fe[1]));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_smp <= rst;
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    grad_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_smp) hold[d] = '0;
      if (gv[d] === 1'b1) begin
        if ((d == 1 ? qb.size() : qs.size()) == 0) check("unexpected_out", 1, 0);
        else begin
          e = (d == 1) ? qb.pop_front() : qs.pop_front();
          check("ix", int'(gix[d]), int'(e.ix));
          check("iy", int'(giy[d]), int'(e.iy));
          check("it", int'(git[d]), int'(e.it));
          hold[d] = e;
        end
        nout[d]++;
        last_out[d] = cyc;
      end else
        check("hold", int'({gix[d], giy[d], git[d]}), int'(hold[d]));
      if (gd[d] === 1'b1) begin
        ndone[d]++;
        done_cyc[d] = cyc;
      end
    end
  end

  function automatic grad_t model(int x, int y);
    grad_t g;
    g.ix = 9'(cf[y-1][x] - cf[y-1][x-2]);
    g.iy = 9'(cf[y][x-1] - cf[y-2][x-1]);
    g.it = 9'(cf[y-1][x-1] - pf[y-1][x-1]);
    return g;
  endfunction

  task automatic fill(int pat, int w, int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        case (pat)
          0: begin cf[y][x] = 64; pf[y][x] = 64; end
          1: begin cf[y][x] = (16 * x) & 255; pf[y][x] = 0; end
          2: begin cf[y][x] = (y == 0) ? 255 : 0; pf[y][x] = 255; end
          default: begin cf[y][x] = int'($urandom_range(255)); pf[y][x] = int'($urandom_range(255)); end
        endcase
      end
  endtask

  task automatic drive_pixel(int d, int x, int y, bit last_fd);
    int h;
    h = (d == 1) ? BH : SH;
    pc = 8'(cf[y][x]);
    pp = 8'(pf[y][x]);
    pv[d] = 1'b1;
    fd[d] = last_fd;
    if (x >= 2 && y >= 2 && y < h) begin
      if (d == 1) qb.push_back(model(x, y));
      else qs.push_back(model(x, y));
    end
    @(posedge clk);
    #1;
    pv[d] = 1'b0;
    fd[d] = 1'b0;
  endtask

  task automatic run_frame(int d, int gap, bit fd_last, int npix);
    int w;
    w = (d == 1) ? BW : SW;
    nout[d] = 0;
    ndone[d] = 0;
    for (int i = 0; i < npix; i++) begin
      while (gap != 0 && int'($urandom_range(99)) < gap) begin
        @(posedge clk);
        #1;
      end
      drive_pixel(d, i % w, i / w, fd_last && i == npix - 1);
    end
    if (!fd_last) begin
      fd[d] = 1'b1;
      @(posedge clk);
      #1;
      fd[d] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string name, int d, int err);
    check({name, "_valid"}, int'(gv[d]), 0);
    check({name, "_ix"}, int'(gix[d]), 0);
    check({name, "_iy"}, int'(giy[d]), 0);
    check({name, "_it"}, int'(git[d]), 0);
    check({name, "_done"}, int'(gd[d]), 0);
    check({name, "_err"}, int'(fe[d]), err);
  endtask

  task automatic full_frame(string name, int pat, int gap, int err);
    fill(pat, SW, SH);
    run_frame(0, gap, 1'b0, SW * SH);
    check({name, "_nout"}, nout[0], 12);
    check({name, "_ndone"}, ndone[0], 1);
    check({name, "_err"}, int'(fe[0]), err);
    check({name, "_qempty"}, qs.size(), 0);
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 12, 1'b1};
    vt[1] = '{1, 0, 0, 12, 1'b0};
    vt[2] = '{2, 0, 0, 12, 1'b1};
    vt[3] = '{3, 0, 30, 12, 1'b0};
    vt[4] = '{3, 1, 3, (BW - 2) * (BH - 2), 1'b1};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset_s", 0, 0);
    check_idle("reset_b", 1, 0);
    foreach (vt[i]) begin
      fill(vt[i].pat, vt[i].d == 1 ? BW : SW, vt[i].d == 1 ? BH : SH);
      run_frame(vt[i].d, vt[i].gap, vt[i].fd_last, vt[i].d == 1 ? BW * BH : SW * SH);
      check($sformatf("v%0d_nout", i), nout[vt[i].d], vt[i].n_out);
      check($sformatf("v%0d_ndone", i), ndone[vt[i].d], 1);
      check($sformatf("v%0d_done_lag", i), done_cyc[vt[i].d] - last_out[vt[i].d], vt[i].fd_last ? 1 : 2);
      check($sformatf("v%0d_err", i), int'(fe[vt[i].d]), 0);
      check($sformatf("v%0d_qempty", i), vt[i].d == 1 ? qb.size() : qs.size(), 0);
    end
    fill(3, SW, SH);
    run_frame(0, 0, 1'b0, 10);
    check("short_nout", nout[0], 0);
    check("short_ndone", ndone[0], 1);
    check("short_err", int'(fe[0]), 1);
    full_frame("after_short", 3, 20, 1);
    fill(3, SW, SH);
    nout[0] = 0;
    for (int i = 0; i < 20; i++) drive_pixel(0, i % SW, i / SW, 1'b0);
    pc = 8'(cf[2][4]);
    pp = 8'(pf[2][4]);
    pv[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    pv[0] = 1'b0;
    rst = 1'b0;
    check("midrow_nout", nout[0], 2);
    check_idle("midrow_rst", 0, 0);
    check("midrow_qempty", qs.size(), 0);
    full_frame("after_rst", 1, 0, 0);
    fill(3, SW, SH);
    run_frame(0, 0, 1'b0, SW * SH + 2);
    check("ovf_nout", nout[0], 12);
    check("ovf_err", int'(fe[0]), 1);
    check("ovf_qempty", qs.size(), 0);
    full_frame("after_ovf", 1, 10, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
